// File: rtl/arb_pkg.sv
// Shared arbitration constants and the round-robin pointer increment.
package arb_pkg;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    // Wraps explicitly so non-power-of-2 requester counts behave.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/priority_encoder.sv
// Lowest-set-index priority encoder with a valid flag.
module priority_encoder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

    assign valid = |req;

endmodule

// File: rtl/rr_lock_arbiter.sv
// N-way fixed or round-robin arbiter with an optional grant lock for
// multi-cycle transfers; grant is combinational, state moves on accept.
module rr_lock_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned NUM_REQS     = 8,
    parameter int unsigned ARB_MODE     = ARB_RR,
    parameter int unsigned LOCK_ENABLE  = 1,
    parameter int unsigned LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQS-1:0]     requests,
    input  logic                    enable,
    input  logic                    lock,
    output logic [LOG_NUM_REQS-1:0] grant_index,
    output logic [NUM_REQS-1:0]     grant_onehot,
    output logic                    grant_valid,
    output logic                    grant_locked
);

    localparam int unsigned LW = LOG_NUM_REQS;

    logic [LW-1:0]       rr_ptr, rr_ptr_next;
    logic                lock_valid, lock_valid_next;
    logic [LW-1:0]       lock_idx, lock_idx_next;
    logic [NUM_REQS-1:0] rr_mask, masked_req;
    logic [LW-1:0]       masked_idx, unmasked_idx;
    logic                masked_valid, unmasked_valid;
    logic                lock_req, lock_eff, accept;

    assign lock_eff = (LOCK_ENABLE != 0) && lock;

    // Requesters at or above the pointer get first pick.
    always_comb begin
        rr_mask = '0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            rr_mask[i] = (LW'(i) >= rr_ptr);
        end
    end

    assign masked_req = requests & rr_mask;

    priority_encoder #(.WIDTH(NUM_REQS), .IDX_W(LW)) u_enc_masked (
        .req   (masked_req),
        .idx   (masked_idx),
        .valid (masked_valid)
    );

    priority_encoder #(.WIDTH(NUM_REQS), .IDX_W(LW)) u_enc_unmasked (
        .req   (requests),
        .idx   (unmasked_idx),
        .valid (unmasked_valid)
    );

    always_comb begin
        lock_req = 1'b0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            if (LW'(i) == lock_idx) lock_req = requests[i];
        end
    end

    assign grant_valid  = unmasked_valid;
    assign grant_locked = lock_valid;

    // Winner: held lock first, then fixed or rotating priority.
    always_comb begin
        grant_index = '0;
        if (!unmasked_valid) begin
            grant_index = '0;
        end else if (lock_valid && lock_req) begin
            grant_index = lock_idx;
        end else if (ARB_MODE == ARB_FIXED) begin
            grant_index = unmasked_idx;
        end else begin
            grant_index = masked_valid ? masked_idx : unmasked_idx;
        end
    end

    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            grant_onehot[i] = unmasked_valid && (LW'(i) == grant_index);
        end
    end

    assign accept = enable && unmasked_valid;

    // Release happens either on an accepted unlocked transfer or when the
    // locked requester drops, even with the consumer stalled.
    always_comb begin
        rr_ptr_next     = rr_ptr;
        lock_valid_next = lock_valid;
        lock_idx_next   = lock_idx;
        if (accept) begin
            if (ARB_MODE == ARB_RR) begin
                rr_ptr_next = LW'(rr_next(32'(grant_index), NUM_REQS));
            end
            lock_valid_next = lock_eff;
            if (lock_eff) lock_idx_next = grant_index;
        end else if (lock_valid && !lock_req) begin
            lock_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_idx   <= '0;
        end else begin
            rr_ptr     <= rr_ptr_next;
            lock_valid <= lock_valid_next;
            lock_idx   <= lock_idx_next;
        end
    end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Bench for rr_lock_arbiter: three configurations checked against a
// priority-scan reference model.
module tb_rr_lock_arbiter;
    import arb_pkg::*;

    // dut0: N=4 RR lock; dut1: N=5 FIXED no-lock; dut2: N=5 RR lock
    int cfg_n[3]    = '{4, 5, 5};
    int cfg_mode[3] = '{1, 0, 1};
    int cfg_lock[3] = '{1, 0, 1};

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] req_in [3];
    logic       en_in  [3];
    logic       lk_in  [3];

    logic [1:0] gi0; logic [3:0] go0; logic gv0, gl0;
    logic [2:0] gi1; logic [4:0] go1; logic gv1, gl1;
    logic [2:0] gi2; logic [4:0] go2; logic gv2, gl2;

    int   obs_idx [3];
    int   obs_oh  [3];
    logic obs_v   [3];
    logic obs_l   [3];

    int m_ptr [3];
    int m_li  [3];
    bit m_lv  [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_lock_arbiter #(.NUM_REQS(4), .ARB_MODE(ARB_RR), .LOCK_ENABLE(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .requests(req_in[0][3:0]), .enable(en_in[0]),
        .lock(lk_in[0]), .grant_index(gi0), .grant_onehot(go0), .grant_valid(gv0),
        .grant_locked(gl0));

    rr_lock_arbiter #(.NUM_REQS(5), .ARB_MODE(ARB_FIXED), .LOCK_ENABLE(0)) dut1 (
        .clk(clk), .reset_n(reset_n), .requests(req_in[1]), .enable(en_in[1]),
        .lock(lk_in[1]), .grant_index(gi1), .grant_onehot(go1), .grant_valid(gv1),
        .grant_locked(gl1));

    rr_lock_arbiter #(.NUM_REQS(5), .ARB_MODE(ARB_RR), .LOCK_ENABLE(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .requests(req_in[2]), .enable(en_in[2]),
        .lock(lk_in[2]), .grant_index(gi2), .grant_onehot(go2), .grant_valid(gv2),
        .grant_locked(gl2));

    always_comb begin
        obs_idx[0] = 32'(gi0); obs_oh[0] = 32'(go0); obs_v[0] = gv0; obs_l[0] = gl0;
        obs_idx[1] = 32'(gi1); obs_oh[1] = 32'(go1); obs_v[1] = gv1; obs_l[1] = gl1;
        obs_idx[2] = 32'(gi2); obs_oh[2] = 32'(go2); obs_v[2] = gv2; obs_l[2] = gl2;
    end

    // Reference winner: scan requesters in priority order; -1 when idle.
    function automatic int model_grant(input int id);
        int n = cfg_n[id];
        logic [4:0] r = req_in[id];
        if (r == 5'd0) return -1;
        if (m_lv[id] && r[m_li[id]]) return m_li[id];
        for (int k = 0; k < n; k++) begin
            int j = (cfg_mode[id] == 0) ? k : (m_ptr[id] + k) % n;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic reset_model();
        for (int id = 0; id < 3; id++) begin
            m_ptr[id] = 0; m_li[id] = 0; m_lv[id] = 0;
        end
    endtask

    task automatic model_edge();
        for (int id = 0; id < 3; id++) begin
            int g = model_grant(id);
            if (en_in[id] && g >= 0) begin
                if (cfg_mode[id] == 1) m_ptr[id] = (g + 1) % cfg_n[id];
                m_lv[id] = lk_in[id] && (cfg_lock[id] != 0);
                if (m_lv[id]) m_li[id] = g;
            end else if (m_lv[id] && !req_in[id][m_li[id]]) begin
                m_lv[id] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input int id, input int req, input bit en, input bit lk);
        int mask = (1 << cfg_n[id]) - 1;
        req_in[id] = 5'(req & mask);
        en_in[id]  = en;
        lk_in[id]  = lk;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_in(0, 4'b1111, 1'b0, 1'b0);
        #12;
        n_checks++;
        if (obs_idx[0] !== 0 || obs_v[0] !== 1'b1 || obs_oh[0] !== 1) begin
            n_fail++;
            $display("FAIL reset_grant: idx=%0d valid=%0b onehot=%0h, expected idx=0 valid=1 onehot=1",
                     obs_idx[0], obs_v[0], obs_oh[0]);
        end
        n_checks++;
        if (obs_l[0] !== 1'b0 || obs_l[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_locked: got %0b/%0b, expected 0/0", obs_l[0], obs_l[2]);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        reset_model();
    endtask

    task automatic test_rr_sweep();
        int seq[5] = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            set_in(0, 4'b1111, 1'b1, 1'b0);
            #1;
            n_checks++;
            if (obs_idx[0] !== seq[k] || obs_v[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_sweep[%0d]: idx=%0d valid=%0b, expected idx=%0d valid=1",
                         k, obs_idx[0], obs_v[0], seq[k]);
            end
            tick();
        end
    endtask

    task automatic test_sparse_wrap();
        int seq[4] = '{1, 3, 1, 3};
        for (int k = 0; k < 4; k++) begin
            set_in(0, 4'b1010, 1'b1, 1'b0);
            #1;
            n_checks++;
            if (obs_idx[0] !== seq[k]) begin
                n_fail++;
                $display("FAIL sparse[%0d]: got %0d expected %0d", k, obs_idx[0], seq[k]);
            end
            tick();
        end
        set_in(0, 4'b0010, 1'b1, 1'b0);  // grant 1 moves pointer to 2
        tick();
        set_in(0, 4'b0001, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (obs_idx[0] !== 0 || obs_oh[0] !== 1) begin
            n_fail++;
            $display("FAIL wrap_path: idx=%0d onehot=%0h, expected idx=0 onehot=1", obs_idx[0], obs_oh[0]);
        end
        tick();
    endtask

    task automatic test_lock();
        set_in(0, 4'b0110, 1'b1, 1'b1);
        #1;
        n_checks++;
        if (obs_idx[0] !== 1) begin
            n_fail++;
            $display("FAIL lock_first: got %0d expected 1", obs_idx[0]);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs_idx[0] !== 1 || obs_l[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL lock_hold[%0d]: idx=%0d locked=%0b, expected idx=1 locked=1",
                         k, obs_idx[0], obs_l[0]);
            end
            tick();
        end
        set_in(0, 4'b0110, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (obs_idx[0] !== 1) begin
            n_fail++;
            $display("FAIL lock_release_xfer: got %0d expected 1", obs_idx[0]);
        end
        tick();
        set_in(0, 4'b0110, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (obs_idx[0] !== 2 || obs_l[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_after: idx=%0d locked=%0b, expected idx=2 locked=0", obs_idx[0], obs_l[0]);
        end
    endtask

    task automatic test_auto_release();
        set_in(0, 4'b0010, 1'b1, 1'b1);
        tick();
        set_in(0, 4'b0100, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (obs_idx[0] !== 2 || obs_l[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_rel_same: idx=%0d locked=%0b, expected idx=2 locked=1", obs_idx[0], obs_l[0]);
        end
        tick();
        n_checks++;
        if (obs_l[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL auto_rel_after: locked=%0b expected 0", obs_l[0]);
        end
    endtask

    task automatic test_mid_lock_reset();
        set_in(0, 4'b0100, 1'b1, 1'b1);
        tick();
        set_in(0, 4'b1111, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (obs_idx[0] !== 2 || obs_l[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_lock: idx=%0d locked=%0b, expected idx=2 locked=1", obs_idx[0], obs_l[0]);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs_l[0] !== 1'b0 || obs_idx[0] !== 0) begin
            n_fail++;
            $display("FAIL mid_reset: idx=%0d locked=%0b, expected idx=0 locked=0", obs_idx[0], obs_l[0]);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        reset_model();
        set_in(0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_fixed5();
        for (int k = 0; k < 3; k++) begin
            set_in(1, 5'b10100, 1'b1, 1'b1);
            #1;
            n_checks++;
            if (obs_idx[1] !== 2 || obs_oh[1] !== 5'b00100 || obs_l[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL fixed5[%0d]: idx=%0d onehot=%0h locked=%0b, expected idx=2 onehot=4 locked=0",
                         k, obs_idx[1], obs_oh[1], obs_l[1]);
            end
            tick();
        end
        set_in(1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_rr5_wrap();
        set_in(2, 5'b01000, 1'b1, 1'b0);  // grant 3 moves pointer to 4
        tick();
        set_in(2, 5'b11111, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (obs_idx[2] !== 4) begin
            n_fail++;
            $display("FAIL rr5_top: got %0d expected 4", obs_idx[2]);
        end
        tick();
        n_checks++;
        if (obs_idx[2] !== 0) begin
            n_fail++;
            $display("FAIL rr5_wrap: got %0d expected 0", obs_idx[2]);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int id = 0; id < 3; id++) begin
                set_in(id, int'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 2) == 0));
            end
            #1;
            for (int id = 0; id < 3; id++) begin
                int g = model_grant(id);
                int e_idx = (g < 0) ? 0 : g;
                int e_oh  = (g < 0) ? 0 : (1 << g);
                n_checks++;
                if (obs_idx[id] !== e_idx || obs_oh[id] !== e_oh || obs_v[id] !== (g >= 0) ||
                    obs_l[id] !== m_lv[id]) begin
                    n_fail++;
                    $display("FAIL random c%0d dut%0d: idx=%0d oh=%0h v=%0b l=%0b, expected idx=%0d oh=%0h v=%0b l=%0b",
                             c, id, obs_idx[id], obs_oh[id], obs_v[id], obs_l[id],
                             e_idx, e_oh, (g >= 0), m_lv[id]);
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int id = 0; id < 3; id++) set_in(id, 0, 1'b0, 1'b0);
        reset_model();
        test_reset();
        test_rr_sweep();
        test_sparse_wrap();
        test_lock();
        test_auto_release();
        test_mid_lock_reset();
        test_fixed5();
        test_rr5_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Parametrised N-way arbiter and successor to the fixed-priority arbiter.
- Selectable fixed or round-robin priority, with an optional grant lock that holds a winner across multi-cycle transfers (e.g. whole Ethernet frames into the shared TX datapath).
- Grant is combinational from `requests` and registered arbitration state; state advances only on an accepted grant.
- Sits in front of shared MAC/FIFO resources wherever multiple queues contend.

Parameters:
- NUM_REQS, 8, number of requesters (≥1).
- ARB_MODE, ARB_RR, ARB_FIXED (0) = lowest index wins; ARB_RR (1) = rotating priority.
- LOCK_ENABLE, 1, 1 = `lock` input honoured; 0 = `lock` ignored and tied off internally.
- LOG_NUM_REQS, $clog2(NUM_REQS), width of `grant_index` (min 1).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- requests  in  NUM_REQS  request vector, bit i = requester i.
- enable  in  1  consumer accepts the current grant this cycle; state updates only when enable && grant_valid.
- lock  in  1  sampled with an accepted grant; 1 = keep this winner.
- grant_index  out  LOG_NUM_REQS  binary index of the winner.
- grant_onehot  out  NUM_REQS  one-hot winner; all-zero when invalid.
- grant_valid  out  1  at least one eligible request.
- grant_locked  out  1  lock state register is set.

Behaviour:
- State registers:
  - `rr_ptr` [LOG_NUM_REQS]: highest-priority index.
  - `lock_valid` [1].
  - `lock_idx` [LOG_NUM_REQS].
  - All cleared to 0 asynchronously while reset_n = 0.
- Outputs are combinational.
  - During reset: `grant_locked` = 0; grant is the fixed-priority winner of `requests`, because `rr_ptr` = 0.
- Grant selection, evaluated in order:
  1. If `lock_valid` && `requests[lock_idx]`, the winner is `lock_idx`.
  2. Otherwise, in ARB_FIXED, the winner is the lowest set index.
  3. Otherwise, in ARB_RR, the winner is the first set index at or above `rr_ptr`, wrapping past NUM_REQS-1 to 0. Implement as a masked priority encode; if the masked vector is empty, use the unmasked encode.
- `grant_valid` = |`requests`. If 0: `grant_index` = 0, `grant_onehot` = 0.
- On a rising edge with `enable` && `grant_valid` (accept):
  - ARB_RR: `rr_ptr` ← (`grant_index` + 1) mod NUM_REQS. The wrap must be explicit for non-power-of-2 NUM_REQS.
  - ARB_FIXED: `rr_ptr` is held at 0.
  - If LOCK_ENABLE && `lock`: `lock_valid` ← 1, `lock_idx` ← `grant_index`.
  - If `lock` = 0: `lock_valid` ← 0. The release cycle is still a granted transfer.
- While locked, `rr_ptr` does not move: the accept rule gives `lock_idx`+1, which is constant.
- Auto-release:
  - If `lock_valid` && !`requests[lock_idx]`, `lock_valid` ← 0 at the next edge regardless of `enable`.
  - In that same cycle the grant already falls through to normal arbitration (rule 2/3).
  - If that grant is also accepted with `lock` = 1, the lock transfers to the new winner.
- `enable` = 0: no state change except auto-release. The grant may change with `requests`; there is no registered hold.
- `enable` = 1 with `grant_valid` = 0: no state change.
- NUM_REQS = 1:
  - `grant_index` = 0, `grant_onehot` = `requests`.
  - Lock state is still maintained and `grant_locked` is reported.
- Asynchronous reset asserted mid-lock: lock clears immediately and `rr_ptr` returns to 0.
- Latency: 0 cycles request→grant; 1 cycle accept→new priority.

Decomposition:
- Package `arb_pkg`: localparams ARB_FIXED = 0, ARB_RR = 1; function `rr_next(idx, n)` for the modulo increment.
- Sub-module: reuse the existing `priority_encoder`, instanced twice (masked and unmasked vectors) for RR.
- Mask generation and the lock mux stay inline.

Test Plan (NUM_REQS = 4, ARB_RR, LOCK_ENABLE = 1 unless stated):
- Reset, then requests = 4'b1111 with enable = 1 for 5 cycles → grant_index sequence 0,1,2,3,0; grant_valid = 1 throughout.
- requests = 4'b1010, enable = 1 → grants 1,3,1,3; next set the pointer to 2 with requests = 4'b0001 → grant 0 via wrap path.
- Lock: requests = 4'b0110, cycle 0 grant 1 accepted with lock = 1 → grant_locked = 1, grant stays 1 for 3 accepts; then lock = 0 on the next accept → following grant 2.
- Auto-release: while locked on 1, drop requests[1] (requests = 4'b0100), enable = 0 → same-cycle grant_index = 2, grant_locked = 0 after the edge.
- Mid-lock async reset: reset_n low for a half cycle while locked on 2 with requests = 4'b1111 → grant_locked = 0 immediately, grant_index = 0 combinationally.
- ARB_FIXED, NUM_REQS = 5, requests = 5'b10100, enable = 1 for 3 cycles → grant 2 every cycle; separately, ARB_RR with NUM_REQS = 5 and grant 4 accepted → pointer wraps to 0.
